// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer that lets two requesters share one ALU.
// Each operation is accepted in IDLE, executed on the ALU for one cycle (EXEC),
// and its registered result is offered back to the owner until taken (RESP).
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero,

    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic               owner_q, owner_d;
    logic [WIDTH-1:0]   aluA_q, aluA_d;
    logic [WIDTH-1:0]   aluB_q, aluB_d;
    logic [SEL_W-1:0]   aluSel_q, aluSel_d;
    logic [WIDTH-1:0]   result0_q, result0_d;
    logic [WIDTH-1:0]   result1_q, result1_d;
    logic               zero0_q, zero0_d;
    logic               zero1_q, zero1_d;

    logic               anyValid;
    logic               grant;
    logic               accept;
    logic               rspTaken;

    // Pick the requester to serve: a lone requester wins, a tie goes to the pointer.
    always_comb begin
        anyValid = req0_valid | req1_valid;
        grant    = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ptr_q;
        end else begin
            grant = req1_valid;
        end
        accept   = (state_q == IDLE) && anyValid;
        rspTaken = owner_q ? rsp1_ready : rsp0_ready;
    end

    // Next-state logic: latch operands on accept, capture the ALU in EXEC, wait in RESP.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        aluA_d    = aluA_q;
        aluB_d    = aluB_q;
        aluSel_d  = aluSel_q;
        result0_d = result0_q;
        result1_d = result1_q;
        zero0_d   = zero0_q;
        zero1_d   = zero1_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = EXEC;
                    owner_d  = grant;
                    ptr_d    = ~grant;
                    aluA_d   = grant ? req1_a   : req0_a;
                    aluB_d   = grant ? req1_b   : req0_b;
                    aluSel_d = grant ? req1_sel : req0_sel;
                end
            end
            EXEC: begin
                state_d = RESP;
                if (owner_q) begin
                    result1_d = alu_out;
                    zero1_d   = alu_zero;
                end else begin
                    result0_d = alu_out;
                    zero0_d   = alu_zero;
                end
            end
            RESP: begin
                if (rspTaken) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 1'b0;
            owner_q   <= 1'b0;
            aluA_q    <= '0;
            aluB_q    <= '0;
            aluSel_q  <= '0;
            result0_q <= '0;
            result1_q <= '0;
            zero0_q   <= 1'b0;
            zero1_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            aluA_q    <= aluA_d;
            aluB_q    <= aluB_d;
            aluSel_q  <= aluSel_d;
            result0_q <= result0_d;
            result1_q <= result1_d;
            zero0_q   <= zero0_d;
            zero1_q   <= zero1_d;
        end
    end

    // Handshake outputs depend only on state, owner and grant.
    always_comb begin
        req0_ready = accept && !grant;
        req1_ready = accept && grant;
        rsp0_valid = (state_q == RESP) && !owner_q;
        rsp1_valid = (state_q == RESP) && owner_q;
        busy       = (state_q != IDLE);
    end

    assign alu_a       = aluA_q;
    assign alu_b       = aluB_q;
    assign alu_sel     = aluSel_q;
    assign rsp0_result = result0_q;
    assign rsp0_zero   = zero0_q;
    assign rsp1_result = result1_q;
    assign rsp1_zero   = zero1_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter with a small behavioural ALU attached.
module tb_alu_arbiter;

    logic        clk;
    logic        rst_n;
    logic        req0_valid, req0_ready;
    logic [31:0] req0_a, req0_b;
    logic [2:0]  req0_sel;
    logic        req1_valid, req1_ready;
    logic [31:0] req1_a, req1_b;
    logic [2:0]  req1_sel;
    logic        rsp0_valid, rsp0_ready, rsp0_zero;
    logic [31:0] rsp0_result;
    logic        rsp1_valid, rsp1_ready, rsp1_zero;
    logic [31:0] rsp1_result;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [2:0]  alu_sel;
    logic        alu_zero;
    logic        busy;

    int assertCount = 0;
    int failCount   = 0;

    alu_arbiter #(.WIDTH(32), .SEL_W(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_result(rsp0_result), .rsp0_zero(rsp0_zero),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_result(rsp1_result), .rsp1_zero(rsp1_zero),
        .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
        .alu_out(alu_out), .alu_zero(alu_zero),
        .busy(busy)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural processor ALU driven by the arbiter's registered operands.
    always_comb begin
        alu_out = 32'h0;
        case (alu_sel)
            3'b000: alu_out = alu_a & alu_b;
            3'b001: alu_out = alu_a | alu_b;
            3'b010: alu_out = alu_a + alu_b;
            3'b110: alu_out = alu_a - alu_b;
            3'b111: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 32'h1 : 32'h0;
            default: alu_out = 32'h0;
        endcase
        alu_zero = (alu_out == 32'h0);
    end

    task automatic applyStimulus(input logic v0, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [2:0] s0, input logic v1, input logic [31:0] a1,
                                 input logic [31:0] b1, input logic [2:0] s1);
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_sel = s0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_sel = s1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        rsp0_ready = 1'b0;
        rsp1_ready = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); @(negedge clk); #1;
        $display("[TB] reset state");
        checkOutput("rst busy", 32'(busy), 0);
        checkOutput("rst req0_ready", 32'(req0_ready), 0);
        checkOutput("rst rsp0_valid", 32'(rsp0_valid), 0);
        checkOutput("rst rsp1_valid", 32'(rsp1_valid), 0);
        checkOutput("rst alu_a", alu_a, 0);
        checkOutput("rst rsp0_result", rsp0_result, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test 1: req0 ADD 5+7
        $display("[TB] req0 ADD");
        @(negedge clk);
        applyStimulus(1, 32'd5, 32'd7, 3'b010, 0, 0, 0, 0);
        #1;
        checkOutput("t1 req0_ready", 32'(req0_ready), 1);
        checkOutput("t1 req1_ready", 32'(req1_ready), 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("t1 exec busy", 32'(busy), 1);
        checkOutput("t1 exec req0_ready", 32'(req0_ready), 0);
        checkOutput("t1 exec rsp0_valid", 32'(rsp0_valid), 0);
        checkOutput("t1 alu_a", alu_a, 32'd5);
        checkOutput("t1 alu_b", alu_b, 32'd7);
        checkOutput("t1 alu_sel", 32'(alu_sel), 32'd2);
        @(negedge clk); #1;
        checkOutput("t1 rsp0_valid", 32'(rsp0_valid), 1);
        checkOutput("t1 rsp0_result", rsp0_result, 32'd12);
        checkOutput("t1 rsp0_zero", 32'(rsp0_zero), 0);
        checkOutput("t1 rsp1_valid", 32'(rsp1_valid), 0);
        rsp0_ready = 1'b1;
        @(negedge clk); #1;
        rsp0_ready = 1'b0;
        checkOutput("t1 idle busy", 32'(busy), 0);
        checkOutput("t1 idle rsp0_valid", 32'(rsp0_valid), 0);
        checkOutput("t1 rsp0_result held", rsp0_result, 32'd12);

        // Test 2: req1 SUB 9-9 with rsp1_ready tied high
        $display("[TB] req1 SUB");
        rsp1_ready = 1'b1;
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 1, 32'd9, 32'd9, 3'b110);
        #1;
        checkOutput("t2 idle busy", 32'(busy), 0);
        checkOutput("t2 req1_ready", 32'(req1_ready), 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("t2 exec busy", 32'(busy), 1);
        @(negedge clk); #1;
        checkOutput("t2 resp busy", 32'(busy), 1);
        checkOutput("t2 rsp1_valid", 32'(rsp1_valid), 1);
        checkOutput("t2 rsp0_valid", 32'(rsp0_valid), 0);
        checkOutput("t2 rsp1_result", rsp1_result, 32'd0);
        checkOutput("t2 rsp1_zero", 32'(rsp1_zero), 1);
        @(negedge clk); #1;
        checkOutput("t2 after busy", 32'(busy), 0);
        checkOutput("t2 after rsp1_valid", 32'(rsp1_valid), 0);

        // Test 3: both requesters continuously valid after reset
        $display("[TB] round robin");
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rsp0_ready = 1'b1;
        rsp1_ready = 1'b1;
        @(negedge clk);
        applyStimulus(1, 32'hF0, 32'h0F, 3'b001, 1, 32'hFF, 32'h3C, 3'b000);
        #1;
        for (int k = 0; k < 8; k++) begin
            int g;
            g = k % 2;
            checkOutput("t3 req0_ready", 32'(req0_ready), (g == 0) ? 32'd1 : 32'd0);
            checkOutput("t3 req1_ready", 32'(req1_ready), (g == 1) ? 32'd1 : 32'd0);
            @(negedge clk); @(negedge clk); #1;
            checkOutput("t3 rsp0_valid", 32'(rsp0_valid), (g == 0) ? 32'd1 : 32'd0);
            checkOutput("t3 rsp1_valid", 32'(rsp1_valid), (g == 1) ? 32'd1 : 32'd0);
            if (g == 0) begin
                checkOutput("t3 rsp0_result", rsp0_result, 32'hFF);
            end else begin
                checkOutput("t3 rsp1_result", rsp1_result, 32'h3C);
            end
            @(negedge clk); #1;
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Test 4: backpressure on rsp0 while req1 waits
        $display("[TB] backpressure");
        rsp0_ready = 1'b0;
        @(negedge clk);
        applyStimulus(1, 32'h100, 32'h001, 3'b001, 0, 0, 0, 0);
        #1;
        checkOutput("t4 req0_ready", 32'(req0_ready), 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 1, 32'hFF, 32'h0F, 3'b000);
        #1;
        checkOutput("t4 exec req1_ready", 32'(req1_ready), 0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            checkOutput("t4 hold rsp0_valid", 32'(rsp0_valid), 1);
            checkOutput("t4 hold rsp0_result", rsp0_result, 32'h101);
            checkOutput("t4 hold req1_ready", 32'(req1_ready), 0);
        end
        rsp0_ready = 1'b1;
        @(negedge clk); #1;
        rsp0_ready = 1'b0;
        checkOutput("t4 release busy", 32'(busy), 0);
        checkOutput("t4 release rsp0_valid", 32'(rsp0_valid), 0);
        checkOutput("t4 release req1_ready", 32'(req1_ready), 1);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("t4 withdraw busy", 32'(busy), 0);
        checkOutput("t4 withdraw alu_a", alu_a, 32'h100);

        // Test 5: req1 SLT 3<8 three times back to back
        $display("[TB] lone requester");
        rsp1_ready = 1'b1;
        applyStimulus(0, 0, 0, 0, 1, 32'd3, 32'd8, 3'b111);
        #1;
        for (int k = 0; k < 3; k++) begin
            checkOutput("t5 req1_ready", 32'(req1_ready), 1);
            @(negedge clk); @(negedge clk); #1;
            checkOutput("t5 rsp1_valid", 32'(rsp1_valid), 1);
            checkOutput("t5 rsp0_valid", 32'(rsp0_valid), 0);
            checkOutput("t5 rsp1_result", rsp1_result, 32'd1);
            checkOutput("t5 rsp1_zero", 32'(rsp1_zero), 0);
            @(negedge clk); #1;
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

        // Test 6: asynchronous reset during EXEC
        $display("[TB] reset mid-operation");
        rsp0_ready = 1'b1;
        @(negedge clk);
        applyStimulus(1, 32'd2, 32'd3, 3'b010, 0, 0, 0, 0);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        checkOutput("t6 exec busy", 32'(busy), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("t6 rst busy", 32'(busy), 0);
        checkOutput("t6 rst alu_a", alu_a, 0);
        checkOutput("t6 rst alu_sel", 32'(alu_sel), 0);
        checkOutput("t6 rst rsp0_result", rsp0_result, 0);
        checkOutput("t6 rst rsp1_result", rsp1_result, 0);
        checkOutput("t6 rst rsp0_valid", 32'(rsp0_valid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            checkOutput("t6 no rsp0_valid", 32'(rsp0_valid), 0);
            checkOutput("t6 idle busy", 32'(busy), 0);
        end
        applyStimulus(1, 32'd1, 32'd1, 3'b010, 0, 0, 0, 0);
        #1;
        checkOutput("t6 req0_ready", 32'(req0_ready), 1);
        @(negedge clk);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); #1;
        checkOutput("t6 rsp0_valid", 32'(rsp0_valid), 1);
        checkOutput("t6 rsp0_result", rsp0_result, 32'd2);
        checkOutput("t6 rsp0_zero", 32'(rsp0_zero), 0);
        @(negedge clk); #1;
        checkOutput("t6 final busy", 32'(busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
